cache_tag_lookup: RTL and testbench
===================================

# cache_tag_lookup

Parametrised N-way set-associative tag store with registered hit detection, per-line valid/dirty state, tree pseudo-LRU replacement and a sweeping flush engine. It sits between the cache control FSM and the data arrays of the LC-3b cache. It generalises the two-way combinational hit check to configurable ways, sets and line size. It also owns the replacement and dirty bookkeeping that the control FSM previously kept itself.

## Interface
Parameters:
- WAYS, 2, associativity; power of two, at least 2
- SETS, 8, number of sets; power of two
- OFFSET_W, 4, line-offset bits; TAG_W = 16 - OFFSET_W - log2(SETS), which is 9 at the defaults

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; asynchronous, active-high
- lookup_req  in  1  lookup request; accepted when lookup_ready is high
- lookup_addr  in  16  lc3b_word address; tag = [15:16-TAG_W], set = [OFFSET_W+log2(SETS)-1:OFFSET_W]
- lookup_write  in  1  lookup is a store; sets dirty on hit
- lookup_ready  out  1  high when the FSM is IDLE and fill_req is low
- resp_valid  out  1  one-cycle pulse carrying the result of the accepted lookup
- resp_hit  out  1  tag matched on a valid way
- resp_way  out  log2(WAYS)  hit way; 0 on miss
- resp_victim_way  out  log2(WAYS)  replacement candidate
- resp_victim_valid  out  1  victim line is valid
- resp_victim_dirty  out  1  victim line is dirty (writeback required)
- resp_victim_tag  out  TAG_W  victim tag, used for the writeback address
- fill_req  in  1  install a line; never stalled
- fill_addr  in  16  line address for the fill
- fill_way  in  log2(WAYS)  target way, normally a prior resp_victim_way
- fill_dirty  in  1  initial dirty value (write-allocate)
- flush_req  in  1  invalidate all lines; ignored unless IDLE
- flush_busy  out  1  high while the flush sweep runs

## Operation
- State per line: tag, valid, dirty. State per set: WAYS-1 PLRU bits.
- Hit:
  - A way hits when its valid bit is set and its tag equals the address tag.
  - Multiple matches are illegal; the lowest index wins.
- Victim selection:
  - The lowest-index invalid way is the victim.
  - If all ways are valid, the PLRU tree victim is used.
- Accepted lookup with a hit:
  - The PLRU state of that set is touched toward the hit way.
  - If lookup_write is set, the hit line's dirty bit is set.
- Miss: no state change.
- Fill:
  - Writes the tag, sets valid=1 and dirty=fill_dirty.
  - Touches PLRU toward fill_way.
- FSM states:
  - IDLE: lookups and fills are served. flush_req goes to FLUSH with set counter 0.
  - FLUSH: clears valid, dirty and PLRU of set[cnt] each cycle. cnt counts up; at cnt == SETS-1 the FSM returns to IDLE. The counter does not wrap.
- In FLUSH: lookup_ready=0 and fill_req is ignored.
- The block performs no writebacks on flush. The controller drains dirty lines before issuing flush_req.

## Timing
- Lookup latency is 1:
  - Accept at edge k; resp_* are registered at edge k.
  - resp_* are valid in cycle k+1 with resp_valid=1.
  - resp_valid is 0 in every cycle with no accepted lookup.
- Back-to-back lookups are allowed, one per cycle. Each result reflects all updates committed at earlier edges, including the previous lookup's PLRU and dirty update.
- A fill commits at its edge. A lookup in the next cycle sees the new line.
- When fill_req and lookup_req are asserted in the same cycle, lookup_ready is 0 and the fill wins.
- A flush takes exactly SETS cycles after the accepting edge. flush_busy is high for those SETS cycles.
- Reset (asynchronous; applies mid-lookup and mid-flush):
  - All valid, dirty and PLRU bits are cleared; FSM returns to IDLE; cnt=0.
  - resp_* are all 0; lookup_ready=1; flush_busy=0.
  - Tags are not reset.

## Structure
- lc3b_types gains:
  - cache geometry defaults (WAYS, SETS, OFFSET_W)
  - the cache_flush_state_t enum {IDLE, FLUSH}
- One sub-module, plru_tree:
  - Purely combinational.
  - Takes the WAYS-1 PLRU bits and produces the victim way.
  - Takes the PLRU bits plus a touched way and produces the next PLRU bits.
- Tag, valid, dirty and PLRU arrays are flop-based in cache_tag_lookup.

## Test plan
- Reset, then lookup 0x1230 (tag 0x024, set 3) -> next cycle resp_valid=1, hit=0, victim_way=0, victim_valid=0.
- Fill 0x1230 to way 0, then a lookup with write=1 -> hit=1, way=0. A following lookup of 0x12B0 (tag 0x025, set 3) -> miss, victim_way=1, victim_valid=0.
- Fill 0x12B0 to way 1, lookup 0x1230 (hit way 0), then lookup 0x1330 (tag 0x026, set 3) -> victim_way=1, victim_valid=1, victim_dirty=0, victim_tag=0x025.
- Lookup 0x12B0 (touch way 1), then lookup 0x1330 -> victim_way=0, victim_dirty=1, victim_tag=0x024.
- flush_req -> flush_busy high for 8 cycles, lookup_ready low. Afterwards lookup 0x1230 -> hit=0. Assert rst at flush cycle 4 -> flush_busy=0 immediately; all sets invalid.
- fill_req and lookup_req asserted in the same cycle -> lookup not accepted, no resp_valid next cycle. The fill is visible to the lookup in the following cycle.

Source files
------------

// File: rtl/cache_tag_lookup_pkg.sv
// Shared geometry defaults and flush FSM state type for the tag store.
package cache_tag_lookup_pkg;

    localparam int LC3B_WORD_W    = 16;
    localparam int CACHE_WAYS     = 2;
    localparam int CACHE_SETS     = 8;
    localparam int CACHE_OFFSET_W = 4;

    typedef enum logic {
        IDLE,
        FLUSH
    } cache_flush_state_t;

endpackage

// File: rtl/cache_tag_lookup_plru_tree.sv
// Combinational tree pseudo-LRU: victim walk and touch update over WAYS-1 heap-ordered bits.
// A node bit of 0 points the victim walk at its left subtree, 1 at its right subtree.
module plru_tree #(
    parameter int WAYS = 2
) (
    input  logic [WAYS-2:0]         bits,
    input  logic [$clog2(WAYS)-1:0] touch_way,
    output logic [$clog2(WAYS)-1:0] victim_way,
    output logic [WAYS-2:0]         next_bits
);

    localparam int WAY_W = $clog2(WAYS);

    always_comb begin
        int   cur;
        logic b;
        victim_way = '0;
        cur        = 0;
        for (int l = 0; l < WAY_W; l++) begin
            b = 1'b0;
            for (int n = 0; n < WAYS - 1; n++) begin
                if (n == cur) b = bits[n];
            end
            victim_way[WAY_W-1-l] = b;
            cur = 2 * cur + 1 + (b ? 1 : 0);
        end
    end

    // Touching a way points every node on its path away from it.
    always_comb begin
        int   cur;
        logic b;
        next_bits = bits;
        cur       = 0;
        for (int l = 0; l < WAY_W; l++) begin
            b = touch_way[WAY_W-1-l];
            for (int n = 0; n < WAYS - 1; n++) begin
                if (n == cur) next_bits[n] = ~b;
            end
            cur = 2 * cur + 1 + (b ? 1 : 0);
        end
    end

endmodule

// File: rtl/cache_tag_lookup.sv
// N-way set-associative tag store: registered hit/victim lookup, valid/dirty/PLRU
// bookkeeping, line fills and a one-set-per-cycle flush sweep.
module cache_tag_lookup
    import cache_tag_lookup_pkg::*;
#(
    parameter int WAYS     = CACHE_WAYS,
    parameter int SETS     = CACHE_SETS,
    parameter int OFFSET_W = CACHE_OFFSET_W
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            lookup_req,
    input  logic [15:0]                                     lookup_addr,
    input  logic                                            lookup_write,
    output logic                                            lookup_ready,
    output logic                                            resp_valid,
    output logic                                            resp_hit,
    output logic [$clog2(WAYS)-1:0]                         resp_way,
    output logic [$clog2(WAYS)-1:0]                         resp_victim_way,
    output logic                                            resp_victim_valid,
    output logic                                            resp_victim_dirty,
    output logic [LC3B_WORD_W-OFFSET_W-$clog2(SETS)-1:0]    resp_victim_tag,
    input  logic                                            fill_req,
    input  logic [15:0]                                     fill_addr,
    input  logic [$clog2(WAYS)-1:0]                         fill_way,
    input  logic                                            fill_dirty,
    input  logic                                            flush_req,
    output logic                                            flush_busy
);

    localparam int WAY_W = $clog2(WAYS);
    localparam int SET_W = $clog2(SETS);
    localparam int TAG_W = LC3B_WORD_W - OFFSET_W - SET_W;

    cache_flush_state_t state_reg;
    logic [SET_W-1:0]   flush_cnt_reg;

    logic [TAG_W-1:0]   tag_reg   [SETS][WAYS];
    logic [WAYS-1:0]    valid_reg [SETS];
    logic [WAYS-1:0]    dirty_reg [SETS];
    logic [WAYS-2:0]    plru_reg  [SETS];

    logic [SET_W-1:0]   lookup_set;
    logic [TAG_W-1:0]   lookup_tag;
    logic [SET_W-1:0]   fill_set;
    logic [TAG_W-1:0]   fill_tag;
    logic               accept;
    logic [WAYS-1:0]    match;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic               inv_found;
    logic [WAY_W-1:0]   inv_way;
    logic [WAY_W-1:0]   victim_way;
    logic [WAY_W-1:0]   plru_victim;
    logic [SET_W-1:0]   plru_set;
    logic [WAY_W-1:0]   plru_touch;
    logic [WAYS-2:0]    plru_next;
    logic               unused_offset;

    assign lookup_set    = lookup_addr[OFFSET_W+SET_W-1:OFFSET_W];
    assign lookup_tag    = lookup_addr[15:16-TAG_W];
    assign fill_set      = fill_addr[OFFSET_W+SET_W-1:OFFSET_W];
    assign fill_tag      = fill_addr[15:16-TAG_W];
    assign unused_offset = ^{lookup_addr[OFFSET_W-1:0], fill_addr[OFFSET_W-1:0]};

    // A fill in the same cycle takes the port, so the lookup is held off.
    assign lookup_ready = (state_reg == IDLE) && !fill_req;
    assign accept       = lookup_req && lookup_ready;
    assign flush_busy   = (state_reg == FLUSH);

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
            assign match[gi] = valid_reg[lookup_set][gi] && (tag_reg[lookup_set][gi] == lookup_tag);
        end
    endgenerate

    always_comb begin
        hit       = |match;
        hit_way   = '0;
        inv_found = ~&valid_reg[lookup_set];
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w])                    hit_way = WAY_W'(w);
            if (!valid_reg[lookup_set][w])   inv_way = WAY_W'(w);
        end
        victim_way = inv_found ? inv_way : plru_victim;
    end

    // Fills and lookup hits never update PLRU in the same cycle, so one tree serves both.
    assign plru_set   = fill_req ? fill_set : lookup_set;
    assign plru_touch = fill_req ? fill_way : hit_way;

    plru_tree #(
        .WAYS (WAYS)
    ) u_plru (
        .bits       (plru_reg[plru_set]),
        .touch_way  (plru_touch),
        .victim_way (plru_victim),
        .next_bits  (plru_next)
    );

    always_ff @(posedge clk) begin
        if (state_reg == IDLE && fill_req) begin
            tag_reg[fill_set][fill_way] <= fill_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= IDLE;
            flush_cnt_reg     <= '0;
            resp_valid        <= 1'b0;
            resp_hit          <= 1'b0;
            resp_way          <= '0;
            resp_victim_way   <= '0;
            resp_victim_valid <= 1'b0;
            resp_victim_dirty <= 1'b0;
            resp_victim_tag   <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_reg[s] <= '0;
                dirty_reg[s] <= '0;
                plru_reg[s]  <= '0;
            end
        end else begin
            resp_valid <= accept;
            if (accept) begin
                resp_hit          <= hit;
                resp_way          <= hit_way;
                resp_victim_way   <= victim_way;
                resp_victim_valid <= valid_reg[lookup_set][victim_way];
                resp_victim_dirty <= dirty_reg[lookup_set][victim_way];
                resp_victim_tag   <= tag_reg[lookup_set][victim_way];
            end
            case (state_reg)
                IDLE: begin
                    if (fill_req) begin
                        valid_reg[fill_set][fill_way] <= 1'b1;
                        dirty_reg[fill_set][fill_way] <= fill_dirty;
                        plru_reg[fill_set]            <= plru_next;
                    end else if (accept && hit) begin
                        plru_reg[lookup_set] <= plru_next;
                        if (lookup_write) dirty_reg[lookup_set][hit_way] <= 1'b1;
                    end
                    if (flush_req) begin
                        state_reg     <= FLUSH;
                        flush_cnt_reg <= '0;
                    end
                end
                FLUSH: begin
                    valid_reg[flush_cnt_reg] <= '0;
                    dirty_reg[flush_cnt_reg] <= '0;
                    plru_reg[flush_cnt_reg]  <= '0;
                    if (flush_cnt_reg == SET_W'(SETS - 1)) begin
                        state_reg <= IDLE;
                    end else begin
                        flush_cnt_reg <= flush_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_tag_lookup.sv
// Directed bench for cache_tag_lookup at default geometry (2 ways, 8 sets, 4 offset bits).
module tb_cache_tag_lookup;

    logic        clk = 1'b0;
    logic        rst;
    logic        lookup_req;
    logic [15:0] lookup_addr;
    logic        lookup_write;
    logic        lookup_ready;
    logic        resp_valid;
    logic        resp_hit;
    logic [0:0]  resp_way;
    logic [0:0]  resp_victim_way;
    logic        resp_victim_valid;
    logic        resp_victim_dirty;
    logic [8:0]  resp_victim_tag;
    logic        fill_req;
    logic [15:0] fill_addr;
    logic [0:0]  fill_way;
    logic        fill_dirty;
    logic        flush_req;
    logic        flush_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cache_tag_lookup dut (
        .clk               (clk),
        .rst               (rst),
        .lookup_req        (lookup_req),
        .lookup_addr       (lookup_addr),
        .lookup_write      (lookup_write),
        .lookup_ready      (lookup_ready),
        .resp_valid        (resp_valid),
        .resp_hit          (resp_hit),
        .resp_way          (resp_way),
        .resp_victim_way   (resp_victim_way),
        .resp_victim_valid (resp_victim_valid),
        .resp_victim_dirty (resp_victim_dirty),
        .resp_victim_tag   (resp_victim_tag),
        .fill_req          (fill_req),
        .fill_addr         (fill_addr),
        .fill_way          (fill_way),
        .fill_dirty        (fill_dirty),
        .flush_req         (flush_req),
        .flush_busy        (flush_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_lookup(input logic [15:0] addr, input logic wr);
        lookup_req   = 1'b1;
        lookup_addr  = addr;
        lookup_write = wr;
        step();
        lookup_req   = 1'b0;
        lookup_write = 1'b0;
        $display("lookup addr=0x%04h write=%0b -> valid=%0b hit=%0b way=%0d vway=%0d vvalid=%0b vdirty=%0b vtag=0x%03h",
                 addr, wr, resp_valid, resp_hit, resp_way, resp_victim_way,
                 resp_victim_valid, resp_victim_dirty, resp_victim_tag);
    endtask

    task automatic do_fill(input logic [15:0] addr, input logic [0:0] way, input logic dirty);
        fill_req   = 1'b1;
        fill_addr  = addr;
        fill_way   = way;
        fill_dirty = dirty;
        step();
        fill_req   = 1'b0;
        $display("fill addr=0x%04h way=%0d dirty=%0b", addr, way, dirty);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        lookup_req   = 1'b0;
        lookup_addr  = '0;
        lookup_write = 1'b0;
        fill_req     = 1'b0;
        fill_addr    = '0;
        fill_way     = '0;
        fill_dirty   = 1'b0;
        flush_req    = 1'b0;
        step();
        step();
        check("reset_ready", 32'(lookup_ready), 32'd1);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_flush_busy", 32'(flush_busy), 32'd0);
        check("reset_victim_tag", 32'(resp_victim_tag), 32'd0);
        rst = 1'b0;
        step();

        // Cold miss in set 3
        do_lookup(16'h1230, 1'b0);
        check("cold_valid", 32'(resp_valid), 32'd1);
        check("cold_hit", 32'(resp_hit), 32'd0);
        check("cold_vway", 32'(resp_victim_way), 32'd0);
        check("cold_vvalid", 32'(resp_victim_valid), 32'd0);
        step();
        check("idle_no_resp", 32'(resp_valid), 32'd0);

        // Fill way 0, store hit, then miss on other tag picks invalid way 1
        do_fill(16'h1230, 1'b0, 1'b0);
        do_lookup(16'h1230, 1'b1);
        check("store_hit", 32'(resp_hit), 32'd1);
        check("store_way", 32'(resp_way), 32'd0);
        do_lookup(16'h12B0, 1'b0);
        check("miss2_hit", 32'(resp_hit), 32'd0);
        check("miss2_vway", 32'(resp_victim_way), 32'd1);
        check("miss2_vvalid", 32'(resp_victim_valid), 32'd0);

        // Set full: PLRU picks way 1 after touching way 0
        do_fill(16'h12B0, 1'b1, 1'b0);
        do_lookup(16'h1230, 1'b0);
        check("hit0_way", 32'(resp_way), 32'd0);
        check("hit0_hit", 32'(resp_hit), 32'd1);
        do_lookup(16'h1330, 1'b0);
        check("plru1_hit", 32'(resp_hit), 32'd0);
        check("plru1_vway", 32'(resp_victim_way), 32'd1);
        check("plru1_vvalid", 32'(resp_victim_valid), 32'd1);
        check("plru1_vdirty", 32'(resp_victim_dirty), 32'd0);
        check("plru1_vtag", 32'(resp_victim_tag), 32'h025);

        // Touch way 1, victim flips to dirty way 0
        do_lookup(16'h12B0, 1'b0);
        check("hit1_way", 32'(resp_way), 32'd1);
        do_lookup(16'h1330, 1'b0);
        check("plru0_vway", 32'(resp_victim_way), 32'd0);
        check("plru0_vvalid", 32'(resp_victim_valid), 32'd1);
        check("plru0_vdirty", 32'(resp_victim_dirty), 32'd1);
        check("plru0_vtag", 32'(resp_victim_tag), 32'h024);

        // Full flush with a lookup held pending throughout
        flush_req = 1'b1;
        step();
        flush_req   = 1'b0;
        lookup_req  = 1'b1;
        lookup_addr = 16'h1230;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("flush_busy_c%0d", i + 1), 32'(flush_busy), 32'd1);
            check($sformatf("flush_ready_c%0d", i + 1), 32'(lookup_ready), 32'd0);
            step();
            check($sformatf("flush_no_resp_c%0d", i + 1), 32'(resp_valid), 32'd0);
        end
        $display("flush sweep done busy=%0b ready=%0b", flush_busy, lookup_ready);
        check("flush_done_busy", 32'(flush_busy), 32'd0);
        check("flush_done_ready", 32'(lookup_ready), 32'd1);
        do_lookup(16'h1230, 1'b0);
        check("post_flush_valid", 32'(resp_valid), 32'd1);
        check("post_flush_hit", 32'(resp_hit), 32'd0);
        check("post_flush_vvalid", 32'(resp_victim_valid), 32'd0);
        check("post_flush_vdirty", 32'(resp_victim_dirty), 32'd0);

        // Reset in flush cycle 4: set 3 and set 7 not yet swept, reset must clear them
        do_fill(16'h1230, 1'b0, 1'b1);
        do_fill(16'h0070, 1'b1, 1'b1);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        step();
        step();
        step();
        check("flush_c4_busy", 32'(flush_busy), 32'd1);
        rst = 1'b1;
        #1;
        $display("reset mid-flush busy=%0b ready=%0b", flush_busy, lookup_ready);
        check("rst_flush_busy", 32'(flush_busy), 32'd0);
        check("rst_flush_ready", 32'(lookup_ready), 32'd1);
        check("rst_flush_resp", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        do_lookup(16'h1230, 1'b0);
        check("rst_set3_hit", 32'(resp_hit), 32'd0);
        check("rst_set3_vvalid", 32'(resp_victim_valid), 32'd0);
        do_lookup(16'h0070, 1'b0);
        check("rst_set7_hit", 32'(resp_hit), 32'd0);
        check("rst_set7_vvalid", 32'(resp_victim_valid), 32'd0);

        // Fill and lookup collide: fill wins, lookup sees it a cycle later
        fill_req    = 1'b1;
        fill_addr   = 16'h1230;
        fill_way    = 1'b0;
        fill_dirty  = 1'b0;
        lookup_req  = 1'b1;
        lookup_addr = 16'h1230;
        #1;
        check("collide_ready", 32'(lookup_ready), 32'd0);
        step();
        fill_req = 1'b0;
        $display("collide cycle resp_valid=%0b", resp_valid);
        check("collide_no_resp", 32'(resp_valid), 32'd0);
        step();
        lookup_req = 1'b0;
        $display("after collide resp_valid=%0b hit=%0b way=%0d", resp_valid, resp_hit, resp_way);
        check("after_collide_valid", 32'(resp_valid), 32'd1);
        check("after_collide_hit", 32'(resp_hit), 32'd1);
        check("after_collide_way", 32'(resp_way), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
